// File: rtl/prog_load_ctrl.sv
// rtl/prog_load_ctrl.sv - program loader: RAM clear/load, CPU hold and timed run control
module prog_load_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int CYC_W    = 16,
    parameter int HOLD_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic [CYC_W-1:0]  cmd_max_cycles,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_hold,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [CYC_W-1:0]  cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_HOLD, S_RUN, S_DONE
    } state_t;

    localparam logic [1:0] OP_CLEAR   = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_OOB     = 2'b10;

    // HOLD always lasts at least one cycle, even for HOLD_CYC of 0 or 1
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_CYC > 1) ? HOLD_W'(HOLD_CYC - 1) : '0;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W:0]     count_q;
    logic [CYC_W-1:0]    max_q;
    logic [ADDR_W:0]     idx;
    logic [HOLD_W-1:0]   hold_cnt;

    // One extra address bit exposes addresses past the end of RAM instead of wrapping
    logic [ADDR_W:0]     wide_addr;
    logic                in_bounds;
    logic                last_idx;
    logic                step;
    logic [CYC_W-1:0]    cyc_next;
    logic                limit_now;
    logic                limit_next;

    assign wide_addr  = {1'b0, start_q} + idx;
    assign in_bounds  = ~wide_addr[ADDR_W];
    assign last_idx   = (idx == count_q - 1'b1);
    assign step       = (state == S_CLEAR) || ((state == S_LOAD) && data_valid);
    assign cyc_next   = cycles + 1'b1;
    assign limit_now  = (cycles >= max_q);
    assign limit_next = (cyc_next == max_q);

    // Next-state decode and the combinational RAM write / handshake outputs
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        data_ready = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: next_state = (cmd_count == '0) ? S_DONE : S_CLEAR;
                        OP_LOAD:  next_state = (cmd_count == '0) ? S_DONE : S_LOAD;
                        OP_RUN:   next_state = S_HOLD;
                        default:  next_state = S_DONE;
                    endcase
                end
            end
            S_CLEAR: begin
                ram_we   = in_bounds;
                ram_addr = wide_addr[ADDR_W-1:0];
                if (last_idx) next_state = S_DONE;
            end
            S_LOAD: begin
                data_ready = 1'b1;
                ram_we     = data_valid && in_bounds;
                ram_addr   = wide_addr[ADDR_W-1:0];
                ram_wdata  = data_in;
                if (data_valid && last_idx) next_state = S_DONE;
            end
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) next_state = S_RUN;
            end
            S_RUN: begin
                // halt is checked first so it beats a simultaneous timeout
                if (cpu_halt || limit_now || limit_next) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // nothing may reach the RAM or the data stream while reset is asserted
        if (!reset) begin
            ram_we     = 1'b0;
            data_ready = 1'b0;
            ram_addr   = '0;
            ram_wdata  = '0;
        end
    end

    // State register, command capture, progress counters and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            start_q  <= '0;
            count_q  <= '0;
            max_q    <= '0;
            idx      <= '0;
            hold_cnt <= '0;
            status   <= ST_OK;
            cycles   <= '0;
            cpu_hold <= 1'b1;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        start_q  <= cmd_start;
                        count_q  <= cmd_count;
                        max_q    <= cmd_max_cycles;
                        idx      <= '0;
                        hold_cnt <= '0;
                        status   <= ST_OK;
                        if (cmd_op == OP_RUN) begin
                            cycles   <= '0;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                S_CLEAR, S_LOAD: begin
                    if (step) begin
                        idx <= idx + 1'b1;
                        if (!in_bounds) status <= ST_OOB;
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (next_state == S_RUN) cpu_hold <= 1'b0;
                end
                S_RUN: begin
                    if (!cpu_halt) begin
                        if (limit_now) begin
                            status   <= ST_TIMEOUT;
                            cpu_hold <= 1'b1;
                        end else begin
                            cycles <= cyc_next;
                            if (limit_next) begin
                                status   <= ST_TIMEOUT;
                                cpu_hold <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb/tb_prog_load_ctrl.sv - self-checking bench for prog_load_ctrl
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_start;
    logic [4:0]  cmd_count;
    logic [15:0] cmd_max_cycles;
    logic        data_valid;
    logic [7:0]  data_in;
    logic        data_ready;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        cpu_hold;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] cycles;

    prog_load_ctrl #(.DATA_W(8), .ADDR_W(4), .CYC_W(16), .HOLD_CYC(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_start(cmd_start), .cmd_count(cmd_count), .cmd_max_cycles(cmd_max_cycles),
        .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .cpu_hold(cpu_hold), .cpu_halt(cpu_halt),
        .busy(busy), .done(done), .status(status), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // model state: expected writes, expected command outcome, values held while idle
    logic [11:0] exp_wq[$];
    logic [11:0] wr_log[$];
    int          wr_cyc[$];
    logic [7:0]  ld_data[$];
    int          exp_status, exp_cycles, exp_hold;
    int          held_status, held_cycles, model_hold;
    int          done_cnt = 0, done_cyc = 0;
    int          last_status = 0, last_cycles = 0, last_hold = 0;
    bit          armed = 1'b0;
    logic [11:0] e;

    // Compare process: every write against the model, every done against the outcome
    always @(negedge clk) begin
        if (armed) begin
            if (!reset) begin
                chk(ram_we == 1'b0, "we_in_reset", ram_we, 0);
            end else begin
                chk(busy == !cmd_ready, "busy_vs_ready", busy, !cmd_ready);
                if (ram_we) begin
                    wr_log.push_back({ram_addr, ram_wdata});
                    wr_cyc.push_back(cyc);
                    if (exp_wq.size() == 0) begin
                        chk(1'b0, "unexpected_write", {ram_addr, ram_wdata}, 0);
                    end else begin
                        e = exp_wq.pop_front();
                        chk({ram_addr, ram_wdata} == e, "write_addr_data", {ram_addr, ram_wdata}, e);
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    last_status = status;
                    last_cycles = cycles;
                    last_hold = cpu_hold;
                    chk(status == exp_status[1:0], "done_status", status, exp_status);
                    chk(cycles == exp_cycles[15:0], "done_cycles", cycles, exp_cycles);
                    chk(cpu_hold == exp_hold[0], "done_cpu_hold", cpu_hold, exp_hold);
                    chk(exp_wq.size() == 0, "writes_outstanding", exp_wq.size(), 0);
                    held_status = exp_status;
                    held_cycles = exp_cycles;
                    model_hold = exp_hold;
                end else if (cmd_ready) begin
                    chk(cpu_hold == model_hold[0], "idle_cpu_hold", cpu_hold, model_hold);
                    chk(status == held_status[1:0], "idle_status", status, held_status);
                    chk(cycles == held_cycles[15:0], "idle_cycles", cycles, held_cycles);
                    chk(data_ready == 1'b0, "idle_data_ready", data_ready, 0);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk(cmd_ready == 1'b1, {tag, "_cmd_ready"}, cmd_ready, 1);
        chk(data_ready == 1'b0, {tag, "_data_ready"}, data_ready, 0);
        chk(ram_we == 1'b0, {tag, "_ram_we"}, ram_we, 0);
        chk(ram_addr == 4'd0, {tag, "_ram_addr"}, ram_addr, 0);
        chk(ram_wdata == 8'd0, {tag, "_ram_wdata"}, ram_wdata, 0);
        chk(cpu_hold == 1'b1, {tag, "_cpu_hold"}, cpu_hold, 1);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(done == 1'b0, {tag, "_done"}, done, 0);
        chk(status == 2'b00, {tag, "_status"}, status, 0);
        chk(cycles == 16'd0, {tag, "_cycles"}, cycles, 0);
    endtask

    task automatic issue(input int op, input int st, input int cnt, input int mx, output int acc);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 50, "ready_wait", n, 50);
        cmd_valid = 1'b1;
        cmd_op = 2'(op);
        cmd_start = 4'(st);
        cmd_count = 5'(cnt);
        cmd_max_cycles = 16'(mx);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int done_before);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(n < 300, "idle_wait", n, 300);
        chk(done_cnt == done_before + 1, "one_done_pulse", done_cnt, done_before + 1);
    endtask

    task automatic do_clear(input int st, input int cnt, output int acc);
        int d0;
        bit oob;
        oob = 1'b0;
        wr_log.delete(); wr_cyc.delete();
        for (int i = 0; i < cnt; i++) begin
            if (st + i < 16) exp_wq.push_back({4'(st + i), 8'h00});
            else oob = 1'b1;
        end
        exp_status = oob ? 2 : 0;
        exp_cycles = held_cycles;
        exp_hold = model_hold;
        d0 = done_cnt;
        issue(0, st, cnt, 0, acc);
        wait_idle(d0);
    endtask

    task automatic do_load(input int st, input int cnt, input int gap_at, output int acc);
        int d0;
        bit oob;
        oob = 1'b0;
        wr_log.delete(); wr_cyc.delete();
        for (int i = 0; i < cnt; i++) begin
            if (st + i < 16) exp_wq.push_back({4'(st + i), ld_data[i]});
            else oob = 1'b1;
        end
        exp_status = oob ? 2 : 0;
        exp_cycles = held_cycles;
        exp_hold = model_hold;
        d0 = done_cnt;
        issue(1, st, cnt, 0, acc);
        for (int i = 0; i < cnt; i++) begin
            if (i == gap_at) begin
                data_valid = 1'b0;
                @(posedge clk); #1;
            end
            data_valid = 1'b1;
            data_in = ld_data[i];
            @(posedge clk); #1;
        end
        data_valid = 1'b0;
        wait_idle(d0);
    endtask

    // h = run cycle (0 = first cycle after cpu_hold drops) at which halt rises, -1 = never
    task automatic do_run(input int mx, input int h, output int hc);
        int d0, acc, n, last_run;
        last_run = (mx == 0) ? 0 : mx - 1;
        if (h >= 0 && h <= last_run) begin
            exp_status = 0; exp_cycles = h; exp_hold = 0;
        end else begin
            exp_status = 1; exp_cycles = mx; exp_hold = 1;
        end
        d0 = done_cnt;
        issue(2, 0, 0, mx, acc);
        hc = 0; n = 0;
        while (cpu_hold && n < 20) begin
            hc++;
            @(posedge clk); #1;
            n++;
        end
        chk(n < 20, "hold_release_wait", n, 20);
        n = 0;
        while (busy && n < 300) begin
            cpu_halt = (h >= 0 && n >= h);
            @(posedge clk); #1;
            n++;
        end
        cpu_halt = 1'b0;
        chk(n < 300, "run_wait", n, 300);
        chk(done_cnt == d0 + 1, "one_done_pulse", done_cnt, d0 + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int acc, hc, d0;
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_start = '0; cmd_count = '0; cmd_max_cycles = '0;
        data_valid = 1'b0; data_in = '0; cpu_halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        reset = 1'b1;
        held_status = 0; held_cycles = 0; model_hold = 1;
        armed = 1'b1;
        @(posedge clk); #1;

        // CLEAR 3/4: four consecutive zero writes then done
        do_clear(3, 4, acc);
        chk(wr_log.size() == 4, "clr_nwrites", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk(wr_log[0] == 12'h300, "clr_w0", wr_log[0], 12'h300);
            chk(wr_log[3] == 12'h600, "clr_w3", wr_log[3], 12'h600);
            chk(wr_cyc[0] == acc, "clr_first_cyc", wr_cyc[0], acc);
            chk(wr_cyc[3] == acc + 3, "clr_last_cyc", wr_cyc[3], acc + 3);
        end
        chk(done_cyc == acc + 4, "clr_done_cyc", done_cyc, acc + 4);
        chk(last_status == 0, "clr_status", last_status, 0);

        // CLEAR running off the end of RAM
        do_clear(14, 3, acc);
        chk(last_status == 2, "clr_oob_status", last_status, 2);
        chk(wr_log.size() == 2, "clr_oob_nwrites", wr_log.size(), 2);

        // LOAD 14/4 with one gap: only 14 and 15 written, status OOB
        ld_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_load(14, 4, 2, acc);
        chk(wr_log.size() == 2, "ld_oob_nwrites", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk(wr_log[0] == 12'hEA1, "ld_oob_w0", wr_log[0], 12'hEA1);
            chk(wr_log[1] == 12'hFB2, "ld_oob_w1", wr_log[1], 12'hFB2);
        end
        chk(last_status == 2, "ld_oob_status", last_status, 2);

        // LOAD count 0: done the cycle after acceptance, no writes
        do_load(5, 0, -1, acc);
        chk(done_cyc == acc, "ld0_done_cyc", done_cyc, acc);
        chk(wr_log.size() == 0, "ld0_nwrites", wr_log.size(), 0);
        chk(last_status == 0, "ld0_status", last_status, 0);

        // full-depth LOAD with a gap
        ld_data.delete();
        for (int i = 0; i < 16; i++) ld_data.push_back(8'(8'h40 + i * 3));
        do_load(0, 16, 7, acc);
        chk(wr_log.size() == 16, "ld_full_nwrites", wr_log.size(), 16);

        // reserved op passes through DONE
        exp_status = 0; exp_cycles = held_cycles; exp_hold = model_hold;
        d0 = done_cnt;
        issue(3, 2, 3, 9, acc);
        wait_idle(d0);
        chk(done_cyc == acc, "nop_done_cyc", done_cyc, acc);

        // RUN max 100, halt 7 cycles after hold drops
        do_run(100, 7, hc);
        chk(hc == 2, "run_hold_len", hc, 2);
        chk(last_status == 0, "run_ok_status", last_status, 0);
        chk(last_cycles == 7, "run_ok_cycles", last_cycles, 7);
        repeat (3) @(posedge clk);
        #1;
        chk(cpu_hold == 1'b0, "run_ok_hold_stays", cpu_hold, 0);
        do_clear(5, 1, acc);
        chk(cpu_hold == 1'b0, "hold_after_clear", cpu_hold, 0);

        // RUN max 5, no halt: timeout
        do_run(5, -1, hc);
        chk(last_status == 1, "run_to_status", last_status, 1);
        chk(last_cycles == 5, "run_to_cycles", last_cycles, 5);
        chk(last_hold == 1, "run_to_hold", last_hold, 1);

        // run boundaries: zero limit, halt on the limit cycle, halt on first cycle, halt too late
        do_run(0, -1, hc);
        chk(last_status == 1, "run_max0_status", last_status, 1);
        do_run(3, 2, hc);
        chk(last_cycles == 2, "run_tie_cycles", last_cycles, 2);
        do_run(3, 0, hc);
        do_run(4, 4, hc);
        chk(last_status == 1, "run_late_halt_status", last_status, 1);

        // reset after 2 of 4 LOAD beats
        ld_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_log.delete();
        for (int i = 0; i < 4; i++) exp_wq.push_back({4'(i), ld_data[i]});
        exp_status = 0; exp_cycles = held_cycles; exp_hold = model_hold;
        d0 = done_cnt;
        issue(1, 0, 4, 0, acc);
        for (int i = 0; i < 2; i++) begin
            data_valid = 1'b1;
            data_in = ld_data[i];
            @(posedge clk); #1;
        end
        chk(exp_wq.size() == 2, "rst_mid_consumed", exp_wq.size(), 2);
        data_valid = 1'b1;
        data_in = 8'hEE;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midrst");
        exp_wq.delete();
        held_status = 0; held_cycles = 0; model_hold = 1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        reset = 1'b1;
        chk(done_cnt == d0, "midrst_no_done", done_cnt, d0);
        chk(wr_log.size() == 2, "midrst_nwrites", wr_log.size(), 2);

        // recovery after reset
        do_clear(0, 2, acc);
        chk(wr_log.size() == 2, "recover_nwrites", wr_log.size(), 2);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
